// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe
// Brief    : Elastic DEPTH-stage register pipeline with valid/ready flow
//            control, bubble collapse, flush and a registered occupancy count.
//            Optional macro REG_PIPE_CLEAR_EN makes empty stages reload RESET_VAL.
// Revision : 1.0
// ============================================================================
module reg_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("reg_pipe: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("reg_pipe: WIDTH must be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH-1:0]            valid_nxt;
  logic [DEPTH-1:0]            src_valid;
  logic [DEPTH-1:0]            ready;
  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               count_nxt;
  logic                        tail_full;

  // ready_i = !valid_i || ready_(i+1) unrolled: a stage is blocked only when it
  // and every stage after it are full and the sink is stalled.
  always_comb begin
    tail_full = 1'b1;
    ready     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & stage_valid[i];
      ready[i]  = !tail_full || out_ready;
    end
  end

  assign in_ready = ready[0] && !flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_src
      if (i == 0) begin : g_head
        assign src_valid[i] = in_valid && !flush;
        assign src_data[i]  = in_data;
      end else begin : g_body
        assign src_valid[i] = stage_valid[i-1];
        assign src_data[i]  = stage_data[i-1];
      end
    end
  endgenerate

  always_comb begin
    valid_nxt = stage_valid;
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_nxt[i] = 1'b0;
      end else if (ready[i]) begin
        valid_nxt[i] = src_valid[i];
      end
      count_nxt = count_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      count_q     <= '0;
    end else begin
      stage_valid <= valid_nxt;
      count_q     <= count_nxt;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             load;
      logic             clear;
      logic [WIDTH-1:0] data_r;

      assign load = !flush && ready[i] && src_valid[i];
`ifdef REG_PIPE_CLEAR_EN
      assign clear = flush || (ready[i] && !src_valid[i]);
`else
      // Empty stages keep stale data to avoid needless toggling.
      assign clear = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          data_r <= RESET_VAL;
        end else if (load) begin
          data_r <= src_data[i];
        end
      end

      assign stage_data[i] = data_r;
    end
  endgenerate

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign count     = count_q;

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    int'(count_q) <= DEPTH);

  a_count_pop : assert property (@(posedge clk) disable iff (rst)
    int'(count_q) == $countones(stage_valid));

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// Testbench for reg_pipe: directed scenarios on an 8-bit, 3-stage instance plus
// scoreboarded random traffic on 1-stage and 4-stage instances.
module tb_reg_pipe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       a_in_valid = 1'b0, a_out_ready = 1'b0, a_in_ready, a_out_valid;
  logic [7:0] a_in_data = 8'h00, a_out_data;
  logic [0:0] a_count;

  logic       b_in_valid = 1'b0, b_out_ready = 1'b0, b_in_ready, b_out_valid;
  logic [7:0] b_in_data = 8'h00, b_out_data;
  logic [2:0] b_count;

  logic       no_flush = 1'b0;

  int checks = 0;
  int errors = 0;

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count));

  reg_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(no_flush), .count(a_count));

  reg_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(no_flush), .count(b_count));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL reset_out_data got=%0h exp=a5", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_stream();
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      in_data  = (c < 3) ? w[c] : 8'h00;
      #1;
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%0h exp=1", c, in_ready); end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_data !== w[c-3]) begin
          errors++; $display("FAIL stream_out c=%0d got=%0h/%0h exp=1/%0h", c, out_valid, out_data, w[c-3]); end
      end
      if (c == 3) begin
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL stream_count got=%0d exp=3", count); end
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got=%0h exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [5];
    int nxt, got;
    logic in_x, out_x;
    for (int i = 0; i < 5; i++) w[i] = 8'h41 + 8'(i);
    nxt = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = w[nxt];
      #1;
      in_x = in_ready;
      step();
      if (in_x) nxt++;
    end
    #1;
    checks++; if (nxt !== 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", nxt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%0h exp=0", in_ready); end
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_count_full got=%0d exp=3", count); end
    checks++; if (out_data !== 8'h41) begin errors++; $display("FAIL bp_head got=%0h exp=41", out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drain got=%0h exp=1", in_ready); end
    for (int c = 0; c < 20 && got < 5; c++) begin
      in_valid = (nxt < 5);
      in_data  = (nxt < 5) ? w[nxt] : 8'h00;
      #1;
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        checks++; if (out_data !== w[got]) begin errors++; $display("FAIL bp_order idx=%0d got=%0h exp=%0h", got, out_data, w[got]); end
        got++;
      end
      step();
      if (in_x) nxt++;
      if (c == 0) begin
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_count_swap got=%0d exp=3", count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (got !== 5 || nxt !== 5) begin errors++; $display("FAIL bp_totals got=%0d/%0d exp=5/5", got, nxt); end
    #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0d/%0h exp=0/0", count, out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'hB7; step();
    in_valid = 1'b0; step();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bubble_count got=%0d exp=2", count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL bubble_head got=%0h/%0h exp=1/5a", out_valid, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hB7) begin errors++; $display("FAIL bubble_b2b got=%0h/%0h exp=1/b7", out_valid, out_data); end
    step();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bubble_empty got=%0h/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    logic [7:0] exp_data;
`ifdef REG_PIPE_CLEAR_EN
    exp_data = 8'hA5;
`else
    exp_data = 8'h71;
`endif
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h71 + 8'(i); step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_data !== exp_data) begin errors++; $display("FAIL flush_out_data got=%0h exp=%0h", out_data, exp_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak c=%0d got=%0h exp=0", c, out_valid); end
    end
  endtask

  task automatic test_rst_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=2", count); end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL midrst_out_data got=%0h exp=a5", out_data); end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_lost got=%0h exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] na, nb;
    logic       ax, bx;
    na = 8'h00; nb = 8'h80;
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_in_data   = na;
      b_in_valid  = ($urandom_range(0, 2) != 0);
      b_out_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      b_in_data   = nb;
      #1;
      checks++; if (int'(a_count) != qa.size()) begin errors++; $display("FAIL rnd_d1_count c=%0d got=%0d exp=%0d", c, a_count, qa.size()); end
      checks++; if (int'(b_count) != qb.size() || b_count > 3'd4) begin errors++; $display("FAIL rnd_d4_count c=%0d got=%0d exp=%0d", c, b_count, qb.size()); end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL rnd_d1_spurious c=%0d got=%0h exp=none", c, a_out_data); end
        else begin
          if (a_out_data !== qa[0]) begin errors++; $display("FAIL rnd_d1_data c=%0d got=%0h exp=%0h", c, a_out_data, qa[0]); end
          void'(qa.pop_front());
        end
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL rnd_d4_spurious c=%0d got=%0h exp=none", c, b_out_data); end
        else begin
          if (b_out_data !== qb[0]) begin errors++; $display("FAIL rnd_d4_data c=%0d got=%0h exp=%0h", c, b_out_data, qb[0]); end
          void'(qb.pop_front());
        end
      end
      ax = a_in_valid && a_in_ready;
      bx = b_in_valid && b_in_ready;
      step();
      if (ax) begin qa.push_back(na); na = na + 8'd1; end
      if (bx) begin qb.push_back(nb); nb = nb + 8'd1; end
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_rst_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
